// File: rtl/kernel_mem_ack_tracker.sv
// Kernel-to-fabric memory bridge: outstanding read/write limits and kernel writeack generation.
// Define KMEM_LOCAL_WRACK_EN to ack writes locally on last-beat acceptance instead of fabric responses.
module kernel_mem_ack_tracker #(
   parameter int ADDR_WIDTH       = 48,
   parameter int DATA_WIDTH       = 512,
   parameter int BURSTCOUNT_WIDTH = 5,
   parameter int BYTEENABLE_WIDTH = 64,
   parameter int MAX_WR_BURSTS    = 64,
   parameter int MAX_RD_BEATS     = 256
) (
   input  logic                                   clk,
   input  logic                                   reset_n,
   input  logic                                   k_read,
   input  logic                                   k_write,
   input  logic [ADDR_WIDTH-1:0]                  k_address,
   input  logic [BURSTCOUNT_WIDTH-1:0]            k_burstcount,
   input  logic [DATA_WIDTH-1:0]                  k_writedata,
   input  logic [BYTEENABLE_WIDTH-1:0]            k_byteenable,
   output logic                                   k_waitrequest,
   output logic [DATA_WIDTH-1:0]                  k_readdata,
   output logic                                   k_readdatavalid,
   output logic                                   k_writeack,
   output logic                                   m_read,
   output logic                                   m_write,
   output logic [ADDR_WIDTH-1:0]                  m_address,
   output logic [BURSTCOUNT_WIDTH-1:0]            m_burstcount,
   output logic [DATA_WIDTH-1:0]                  m_writedata,
   output logic [BYTEENABLE_WIDTH-1:0]            m_byteenable,
   input  logic                                   m_waitrequest,
   input  logic [DATA_WIDTH-1:0]                  m_readdata,
   input  logic                                   m_readdatavalid,
   input  logic                                   m_writeresponsevalid,
   output logic [$clog2(MAX_WR_BURSTS+1)-1:0]     wr_outstanding,
   output logic [$clog2(MAX_RD_BEATS+1)-1:0]      rd_outstanding,
   output logic                                   err_sticky
);
   localparam int WR_W = $clog2(MAX_WR_BURSTS+1);
   localparam int RD_W = $clog2(MAX_RD_BEATS+1);
   localparam logic [WR_W-1:0] WR_MAX = WR_W'(MAX_WR_BURSTS);
   localparam logic [RD_W:0]   RD_MAX = (RD_W+1)'(MAX_RD_BEATS);

   typedef enum logic {S_IDLE, S_BURST} wr_state_e;

   wr_state_e                   state_q, state_d;
   logic [BURSTCOUNT_WIDTH-1:0] beat_q, beat_d, len_q, len_d, bc_eff;
   logic [WR_W-1:0]             wr_q, wr_d;
   logic [RD_W-1:0]             rd_q, rd_d;
   logic [RD_W:0]               rd_sum;
   logic                        wrack_q, wrack_d, err_q, err_d, rdv_q;
   logic [DATA_WIDTH-1:0]       rdata_q;
   logic                        hold, wr_gate, rd_gate, wr_acc, rd_acc, wr_first, wr_last;
   logic                        resp_ok, resp_err, rdv_ok;

   assign bc_eff   = (k_burstcount == '0) ? BURSTCOUNT_WIDTH'(1) : k_burstcount;
   assign wr_first = (state_q == S_IDLE);
   assign rd_sum   = (RD_W+1)'(rd_q) + (RD_W+1)'(bc_eff);
   assign rd_gate  = (rd_sum > RD_MAX);

`ifdef KMEM_LOCAL_WRACK_EN
   assign wr_gate  = 1'b0;
   assign resp_ok  = 1'b0;
   assign resp_err = 1'b0;
`else
   // Gate only first beats so a burst already in progress always completes.
   assign wr_gate  = wr_first && (wr_q == WR_MAX);
   assign resp_ok  = m_writeresponsevalid && (wr_q != '0);
   assign resp_err = m_writeresponsevalid && (wr_q == '0);
`endif

   assign hold = !reset_n || (k_write ? wr_gate : (k_read && rd_gate));

   assign m_write       = k_write && !hold;
   assign m_read        = k_read && !k_write && !hold;
   assign m_address     = k_address;
   assign m_burstcount  = k_burstcount;
   assign m_writedata   = k_writedata;
   assign m_byteenable  = k_byteenable;
   assign k_waitrequest = hold || m_waitrequest;

   assign wr_acc  = m_write && !m_waitrequest;
   assign rd_acc  = m_read && !m_waitrequest;
   assign wr_last = wr_acc && (wr_first ? (bc_eff == BURSTCOUNT_WIDTH'(1))
                                        : ((beat_q + 1'b1) == len_q));
   assign rdv_ok  = m_readdatavalid && (rd_q != '0);

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      len_d   = len_q;
      case (state_q)
         S_IDLE: begin
            if (wr_acc) begin
               len_d  = bc_eff;
               beat_d = BURSTCOUNT_WIDTH'(1);
               if (!wr_last) state_d = S_BURST;
            end
         end
         S_BURST: begin
            if (wr_acc) begin
               beat_d = beat_q + 1'b1;
               if (wr_last) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
`ifdef KMEM_LOCAL_WRACK_EN
      wr_d    = '0;
      wrack_d = wr_last;
`else
      wr_d    = wr_q + WR_W'(wr_acc && wr_first) - WR_W'(resp_ok);
      wrack_d = resp_ok;
`endif
      rd_d  = rd_q + (rd_acc ? RD_W'(bc_eff) : '0) - RD_W'(rdv_ok);
      err_d = err_q || resp_err || (m_readdatavalid && !rdv_ok) || (k_read && k_write) ||
              ((k_burstcount == '0) && (rd_acc || (wr_acc && wr_first)));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         len_q   <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         wrack_q <= 1'b0;
         err_q   <= 1'b0;
         rdv_q   <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         len_q   <= len_d;
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         wrack_q <= wrack_d;
         err_q   <= err_d;
         rdv_q   <= m_readdatavalid;
         rdata_q <= m_readdata;
      end
   end

   assign k_writeack      = wrack_q;
   assign k_readdatavalid = rdv_q;
   assign k_readdata      = rdata_q;
   assign wr_outstanding  = wr_q;
   assign rd_outstanding  = rd_q;
   assign err_sticky      = err_q;

endmodule

// File: doc/kernel_mem_ack_tracker.md
# kernel_mem_ack_tracker

Bridge between the BSP-side kernel memory port and the downstream Avalon-MM memory fabric. It enforces outstanding-read and outstanding-write limits and generates the kernel-facing `writeack`, one pulse per completed write burst. On the kernel side it speaks the kernel memory port signal set (`read`, `write`, `writedata`, `address`, `burstcount`, `byteenable` in; `readdata`, `readdatavalid`, `waitrequest`, `writeack` out). On the fabric side it drives a standard Avalon-MM host with write responses.

## Interface
Parameters:
- ADDR_WIDTH, 48: byte address width.
- DATA_WIDTH, 512: data width.
- BURSTCOUNT_WIDTH, 5: burstcount width; legal burstcount is 1..2^(BURSTCOUNT_WIDTH-1).
- BYTEENABLE_WIDTH, 64: DATA_WIDTH/8.
- MAX_WR_BURSTS, 64: maximum write bursts awaiting response.
- MAX_RD_BEATS, 256: maximum read beats requested but not yet returned.

Ports:
- clk  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- k_read, k_write  in  1  kernel commands.
- k_address  in  ADDR_WIDTH  kernel address.
- k_burstcount  in  BURSTCOUNT_WIDTH  kernel burstcount.
- k_writedata  in  DATA_WIDTH  kernel write data.
- k_byteenable  in  BYTEENABLE_WIDTH  kernel byte enables.
- k_waitrequest  out  1  backpressure to kernel.
- k_readdata  out  DATA_WIDTH  read data to kernel.
- k_readdatavalid  out  1  read data valid.
- k_writeack  out  1  one pulse per completed write burst.
- m_read, m_write, m_address, m_burstcount, m_writedata, m_byteenable  out  as kernel side  fabric command.
- m_waitrequest  in  1  fabric backpressure.
- m_readdata  in  DATA_WIDTH  fabric read data.
- m_readdatavalid  in  1  fabric read data valid.
- m_writeresponsevalid  in  1  one per write burst.
- wr_outstanding  out  $clog2(MAX_WR_BURSTS+1)  current write burst count.
- rd_outstanding  out  $clog2(MAX_RD_BEATS+1)  current read beat count.
- err_sticky  out  1  protocol error flag, cleared only by reset.

## Operation
- Command path is combinational pass-through. A gate signal `hold` deasserts m_read/m_write and forces k_waitrequest=1. Otherwise k_waitrequest = m_waitrequest.
- A beat is accepted when m_read or m_write is asserted and m_waitrequest=0.
- Write FSM states:
  - IDLE: on an accepted first beat, latch burstcount, consume one write credit (wr_outstanding+1), set beat counter to 1. If burstcount=1 the burst is complete; otherwise go to BURST.
  - BURST: count accepted beats; on beat count == latched burstcount return to IDLE. No gating is applied mid-burst, so a started burst always completes.
- Write gating: hold is asserted on a first write beat when wr_outstanding == MAX_WR_BURSTS.
- m_writeresponsevalid decrements wr_outstanding, and k_writeack pulses 1 cycle later.
- Reads:
  - An accepted read adds burstcount to rd_outstanding.
  - hold is asserted when rd_outstanding + k_burstcount > MAX_RD_BEATS.
  - Each m_readdatavalid decrements rd_outstanding by 1.
  - m_readdata/m_readdatavalid are registered to k_readdata/k_readdatavalid.
- When an increment and a decrement occur in the same cycle, the counter takes the net result (e.g. +4-1 = +3).
- Errors (each sets err_sticky; operation continues):
  - m_writeresponsevalid with wr_outstanding=0: response ignored, no writeack.
  - m_readdatavalid with rd_outstanding=0: data still forwarded, counter held at 0.
  - Accepted burstcount=0: treated as 1.
  - k_read and k_write asserted together: write forwarded, read blocked.

## Timing
- Reset values: k_readdatavalid=0, k_writeack=0, k_readdata=0, wr_outstanding=0, rd_outstanding=0, err_sticky=0, write FSM in IDLE.
- While reset_n=0, hold=1, so k_waitrequest=1 and m_read=m_write=0.
- Command latency: 0 cycles (combinational).
- Read data latency: 1 cycle from m_readdatavalid to k_readdatavalid.
- Writeack latency: 1 cycle from m_writeresponsevalid to k_writeack.
- Reset asserted mid-burst: FSM returns to IDLE, counters clear, and in-flight responses arriving after reset count as errors.

## Configuration
- KMEM_LOCAL_WRACK_EN defined:
  - k_writeack pulses 1 cycle after the last beat of each write burst is accepted.
  - m_writeresponsevalid is ignored, wr_outstanding is held at 0, and write gating is disabled.
  - Read behaviour is unchanged.
- KMEM_LOCAL_WRACK_EN undefined: response-based writeack as described in Operation.

## Test plan
- Single-beat write, then m_writeresponsevalid 5 cycles later -> wr_outstanding goes 0→1→0; one k_writeack pulse on the cycle after the response.
- Burstcount=4 write with m_waitrequest asserted on beat 2 -> exactly 4 beats forwarded; one credit consumed; FSM back in IDLE after beat 4.
- 64 write bursts issued with no responses -> 65th first beat sees k_waitrequest=1 and m_write=0; one response -> 65th accepted the next cycle.
- MAX_RD_BEATS=256: reads of 16 beats ×16, then one more read of 1 -> held; one m_readdatavalid -> read accepted; rd_outstanding=256.
- Read accept (+8) in the same cycle as m_readdatavalid (-1), starting from 10 -> rd_outstanding=17.
- m_writeresponsevalid with wr_outstanding=0 -> err_sticky=1, no k_writeack. Under KMEM_LOCAL_WRACK_EN, a burstcount=2 write -> k_writeack 1 cycle after beat 2.
